seg_scan_ctrl: RTL

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed display driver: binary load -> 14-step double-dabble -> committed digit registers, scanned every SCAN_DIV cycles.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 1 and dp digits are never blanked).
module seg_scan_ctrl #(
   parameter int         SCAN_DIV   = 10000,
   parameter logic [5:0] BLANK_CODE = 6'd15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_valid,
   output logic        load_ready,
   input  logic [13:0] load_value,
   input  logic [3:0]  load_dp,
   output logic [3:0]  showDigit,
   output logic [5:0]  showNum,
   output logic        ovf
);
   localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

   typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
   state_t state, state_nxt;
   logic   take, commit;

   logic [13:0] bin_q;
   logic [15:0] bcd_q, bcd_adj;
   logic [3:0]  iter_q;
   logic [3:0]  dp_cap_q;
   logic        ovf_cap_q;

   logic [15:0] digit_q, digit_nxt;
   logic [3:0]  dp_q, dp_nxt;
   logic        ovf_nxt;
   logic        shown_q, shown_nxt;

   logic [15:0] cnt_q;
   logic        wrap;
   logic [3:0]  idx_nxt;
   logic [1:0]  sel;
   logic [3:0]  nib;
   logic        lz;
   logic [5:0]  code_nxt;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      load_ready = 1'b0;
      take       = 1'b0;
      commit     = 1'b0;
      case (state)
         IDLE: begin
            load_ready = 1'b1;
            if (load_valid) begin
               take      = 1'b1;
               state_nxt = CONV;
            end
         end
         CONV:    if (iter_q == 4'd13) state_nxt = COMMIT;
         COMMIT: begin
            commit    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Add-3 correction on every BCD nibble before each shift.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < 4; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bin_q     <= '0;
         bcd_q     <= '0;
         iter_q    <= '0;
         dp_cap_q  <= '0;
         ovf_cap_q <= 1'b0;
      end else if (take) begin
         bin_q     <= load_value;
         bcd_q     <= '0;
         iter_q    <= '0;
         dp_cap_q  <= load_dp;
         ovf_cap_q <= (load_value > 14'd9999);
      end else if (state == CONV) begin
         bcd_q  <= {bcd_adj[14:0], bin_q[13]};
         bin_q  <= {bin_q[12:0], 1'b0};
         iter_q <= iter_q + 4'd1;
      end
   end

   always_comb begin
      digit_nxt = digit_q;
      dp_nxt    = dp_q;
      ovf_nxt   = ovf;
      shown_nxt = shown_q;
      if (commit) begin
         digit_nxt = bcd_q;
         dp_nxt    = dp_cap_q;
         ovf_nxt   = ovf_cap_q;
         shown_nxt = 1'b1;
      end
   end

   assign wrap = (cnt_q == DIV_LAST);

   always_comb begin
      idx_nxt = showDigit;
      if (wrap) idx_nxt = (showDigit == 4'd4) ? 4'd1 : showDigit + 4'd1;
   end

   // showNum is built from next-cycle index and contents so a commit landing on a wrap shows up together.
   always_comb begin
      sel = idx_nxt[1:0] - 2'd1;
      nib = digit_nxt[{sel, 2'b00} +: 4];
      lz  = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
      case (sel)
         2'd1:    lz = (digit_nxt[15:4]  == 12'd0);
         2'd2:    lz = (digit_nxt[15:8]  == 8'd0);
         2'd3:    lz = (digit_nxt[15:12] == 4'd0);
         default: lz = 1'b0;
      endcase
      lz = lz & ~dp_nxt[sel];
`endif
      if (!shown_nxt)   code_nxt = BLANK_CODE;
      else if (ovf_nxt) code_nxt = 6'h3F;
      else if (lz)      code_nxt = BLANK_CODE;
      else              code_nxt = {dp_nxt[sel], 1'b0, nib};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         showDigit <= 4'd1;
         showNum   <= BLANK_CODE;
         digit_q   <= '0;
         dp_q      <= '0;
         ovf       <= 1'b0;
         shown_q   <= 1'b0;
      end else begin
         cnt_q     <= wrap ? 16'd0 : cnt_q + 16'd1;
         showDigit <= idx_nxt;
         showNum   <= code_nxt;
         digit_q   <= digit_nxt;
         dp_q      <= dp_nxt;
         ovf       <= ovf_nxt;
         shown_q   <= shown_nxt;
      end
   end
endmodule
